// File: rtl/fetch_pc_btb.sv
// Fetch PC register with a direct-mapped BTB, branch resolution from M,
// mispredict redirect/flush and a saturating mispredict counter.
module fetch_pc_btb #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          ENTRIES  = 128,
   parameter int          IDX_W    = 7
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_F,
   input  logic        predicted_dir,
   input  logic        resolve_valid,
   input  logic [31:0] BPC,
   input  logic [31:0] resolve_target,
   input  logic        actual_result,
   input  logic        pred_taken_M,
   input  logic [31:0] pred_target_M,
   input  logic [31:0] PC_plus4_M,
   output logic [31:0] PC_F,
   output logic        btb_hit,
   output logic        pred_taken_F,
   output logic [31:0] pred_target_F,
   output logic        flush_pipeline,
   output logic [15:0] mispredict_count
);

   localparam int TAG_W = 32 - IDX_W - 2;

   logic [31:0]      pc_q, pc_d;
   logic [15:0]      cnt_q, cnt_d;
   logic [ENTRIES-1:0] valid_q;
   logic [TAG_W-1:0] tag_q    [ENTRIES];
   logic [31:0]      target_q [ENTRIES];

   logic [IDX_W-1:0] ridx, widx;
   logic [TAG_W-1:0] rtag, wtag;
   logic [31:0]      pc_plus4_f;
   logic [31:0]      correct_pc;
   logic             mispredict;
   logic             btb_we;

   assign ridx       = pc_q[IDX_W+1:2];
   assign rtag       = pc_q[31:IDX_W+2];
   assign widx       = BPC[IDX_W+1:2];
   assign wtag       = BPC[31:IDX_W+2];
   assign pc_plus4_f = pc_q + 32'd4;

   // Reset masks the lookup and the flush so nothing stale leaks out while held.
   assign btb_hit       = rst & valid_q[ridx] & (tag_q[ridx] == rtag);
   assign pred_taken_F  = btb_hit & predicted_dir;
   assign pred_target_F = btb_hit ? target_q[ridx] : pc_plus4_f;

   assign mispredict = rst & resolve_valid &
                       ((actual_result != pred_taken_M) |
                        (actual_result & pred_taken_M & (pred_target_M != resolve_target)));
   assign flush_pipeline = mispredict;
   assign correct_pc     = actual_result ? resolve_target : PC_plus4_M;
   assign btb_we         = rst & resolve_valid & actual_result;

   always_comb begin
      pc_d = pc_plus4_f;
      if (mispredict)        pc_d = correct_pc;
      else if (stall_F)      pc_d = pc_q;
      else if (pred_taken_F) pc_d = pred_target_F;
   end

   always_comb begin
      cnt_d = cnt_q;
      if (mispredict && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         pc_q    <= RESET_PC;
         cnt_q   <= '0;
         valid_q <= '0;
      end else begin
         pc_q  <= pc_d;
         cnt_q <= cnt_d;
         if (btb_we) valid_q[widx] <= 1'b1;
      end
   end

   // Tag/target need no reset: an entry is meaningless until its valid bit is set.
   always_ff @(posedge clk) begin
      if (btb_we) begin
         tag_q[widx]    <= wtag;
         target_q[widx] <= resolve_target;
      end
   end

   assign PC_F             = pc_q;
   assign mispredict_count = cnt_q;

endmodule

// File: tb/tb_fetch_pc_btb.sv
// Directed bench for fetch_pc_btb: a behavioural model predicts each cycle's
// outputs and pushes next-state expectations to a scoreboard queue.
module tb_fetch_pc_btb;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall_F, predicted_dir, resolve_valid, actual_result, pred_taken_M;
   logic [31:0] BPC, resolve_target, pred_target_M, PC_plus4_M;
   logic [31:0] PC_F, pred_target_F;
   logic        btb_hit, pred_taken_F, flush_pipeline;
   logic [15:0] mispredict_count;

   fetch_pc_btb dut (
      .clk(clk), .rst(rst), .stall_F(stall_F), .predicted_dir(predicted_dir),
      .resolve_valid(resolve_valid), .BPC(BPC), .resolve_target(resolve_target),
      .actual_result(actual_result), .pred_taken_M(pred_taken_M),
      .pred_target_M(pred_target_M), .PC_plus4_M(PC_plus4_M),
      .PC_F(PC_F), .btb_hit(btb_hit), .pred_taken_F(pred_taken_F),
      .pred_target_F(pred_target_F), .flush_pipeline(flush_pipeline),
      .mispredict_count(mispredict_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [15:0] cnt;
   } exp_t;

   exp_t        sb_q[$];
   int          checks = 0;
   int          errors = 0;

   logic [31:0] m_pc = 32'h0;
   logic [15:0] m_cnt = 16'h0;
   bit          m_valid  [128];
   logic [22:0] m_tag    [128];
   logic [31:0] m_target [128];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   // Entered at posedge+1; drives inputs, checks combinational outputs
   // mid-cycle, then checks registered state just after the next edge.
   task automatic cycle(input logic r, input logic st, input logic pd, input logic rv,
                        input logic [31:0] bpc, input logic [31:0] tgt, input logic act,
                        input logic ptm, input logic [31:0] ptg, input logic [31:0] p4);
      logic [6:0]  idx, widx;
      logic        hit, ptf, mis;
      logic [31:0] ptgf, npc;
      exp_t        e;
      rst = r; stall_F = st; predicted_dir = pd; resolve_valid = rv; BPC = bpc;
      resolve_target = tgt; actual_result = act; pred_taken_M = ptm;
      pred_target_M = ptg; PC_plus4_M = p4;
      #4;
      idx  = m_pc[8:2];
      hit  = r && m_valid[idx] && (m_tag[idx] == m_pc[31:9]);
      ptf  = hit && pd;
      ptgf = hit ? m_target[idx] : m_pc + 32'd4;
      mis  = r && rv && ((act != ptm) || (act && ptm && (ptg != tgt)));
      chk("btb_hit", {31'b0, btb_hit}, {31'b0, hit});
      chk("pred_taken_F", {31'b0, pred_taken_F}, {31'b0, ptf});
      chk("pred_target_F", pred_target_F, ptgf);
      chk("flush", {31'b0, flush_pipeline}, {31'b0, mis});
      if (!r) begin
         npc   = 32'h0;
         m_cnt = 16'h0;
         foreach (m_valid[i]) m_valid[i] = 1'b0;
      end else begin
         if (mis)      npc = act ? tgt : p4;
         else if (st)  npc = m_pc;
         else if (ptf) npc = ptgf;
         else          npc = m_pc + 32'd4;
         if (rv && act) begin
            widx = bpc[8:2];
            m_valid[widx]  = 1'b1;
            m_tag[widx]    = bpc[31:9];
            m_target[widx] = tgt;
         end
         if (mis && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      end
      e.pc = npc; e.cnt = m_cnt;
      sb_q.push_back(e);
      m_pc = npc;
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      chk("PC_F", PC_F, e.pc);
      chk("count", {16'b0, mispredict_count}, {16'b0, e.cnt});
   endtask

   task automatic idle(input logic pd);
      cycle(1'b1, 1'b0, pd, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
   endtask

   // Not-taken mispredict whose fall-through is the wanted PC; never writes the BTB.
   task automatic redirect(input logic [31:0] pc);
      cycle(1'b1, 1'b0, 1'b0, 1'b1, pc - 32'd4, 32'h0, 1'b0, 1'b1, 32'h0, pc);
   endtask

   initial begin
      rst = 1'b0; stall_F = 1'b0; predicted_dir = 1'b0; resolve_valid = 1'b0;
      BPC = '0; resolve_target = '0; actual_result = 1'b0; pred_taken_M = 1'b0;
      pred_target_M = '0; PC_plus4_M = '0;
      foreach (m_valid[i]) m_valid[i] = 1'b0;
      @(posedge clk);
      #1;
      // Reset held two cycles with a live mispredicting resolve on the inputs.
      cycle(1'b0, 1'b0, 1'b1, 1'b1, 32'h10, 32'h40, 1'b1, 1'b0, 32'h0, 32'h14);
      cycle(1'b0, 1'b0, 1'b1, 1'b1, 32'h10, 32'h40, 1'b1, 1'b0, 32'h0, 32'h14);
      chk("reset_pc", PC_F, 32'h0);
      chk("reset_cnt", {16'b0, mispredict_count}, 32'h0);
      repeat (4) idle(1'b1);
      chk("seq_pc", PC_F, 32'h10);

      // Cold taken branch
      cycle(1'b1, 1'b0, 1'b0, 1'b1, 32'h10, 32'h40, 1'b1, 1'b0, 32'h0, 32'h14);
      chk("cold_pc", PC_F, 32'h40);
      chk("cold_cnt", {16'b0, mispredict_count}, 32'h1);
      redirect(32'h10);
      idle(1'b1);
      chk("hit_pc", PC_F, 32'h40);

      // Not-taken mispredict leaves entry alone
      cycle(1'b1, 1'b0, 1'b0, 1'b1, 32'h10, 32'h0, 1'b0, 1'b1, 32'h40, 32'h14);
      chk("nt_pc", PC_F, 32'h14);
      redirect(32'h10);
      idle(1'b0);

      // Target mismatch
      cycle(1'b1, 1'b0, 1'b0, 1'b1, 32'h10, 32'h80, 1'b1, 1'b1, 32'h40, 32'h14);
      chk("tgt_pc", PC_F, 32'h80);
      redirect(32'h10);

      // Same-cycle read/write of index 4: lookup sees old target 0x80
      cycle(1'b1, 1'b0, 1'b1, 1'b1, 32'h10, 32'hC0, 1'b1, 1'b1, 32'hC0, 32'h14);
      chk("rbw_pc", PC_F, 32'h80);
      redirect(32'h10);
      idle(1'b1);
      chk("new_tgt_pc", PC_F, 32'hC0);

      // Stall alone holds; stall with mispredict takes the correct PC
      cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      chk("stall_pc", PC_F, 32'hC0);
      cycle(1'b1, 1'b1, 1'b0, 1'b1, 32'h20, 32'h0, 1'b0, 1'b1, 32'h50, 32'h24);
      chk("stall_flush_pc", PC_F, 32'h24);

      // Aliasing PC shares index with 0x10 but not its tag
      redirect(32'h210);
      idle(1'b1);
      chk("alias_pc", PC_F, 32'h214);

      // Wrap and back-to-back redirects
      redirect(32'hFFFF_FFFC);
      idle(1'b0);
      chk("wrap_pc", PC_F, 32'h0);
      redirect(32'h500);
      redirect(32'h600);

      // Reset mid-operation discards a pending BTB write
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h300, 32'h700, 1'b1, 1'b0, 32'h0, 32'h304);
      redirect(32'h300);
      idle(1'b1);
      redirect(32'h10);
      idle(1'b1);
      chk("post_reset_pc", PC_F, 32'h14);

      // Saturation
      for (int i = 0; i < 65540; i++) redirect(32'h100);
      chk("sat_cnt", {16'b0, mispredict_count}, 32'h0000_FFFF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
